// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control field widths, m-field bit positions
// and the wb/m/exe field types used by the ID/EX stage.
package mips_pipe_pkg;

  localparam int WB_W  = 2;
  localparam int M_W   = 3;
  localparam int EXE_W = 4;

  localparam int M_BRANCH_BIT   = 0;
  localparam int M_MEMREAD_BIT  = 1;
  localparam int M_MEMWRITE_BIT = 2;

  typedef logic [WB_W-1:0]  wb_ctrl_t;
  typedef logic [M_W-1:0]   m_ctrl_t;
  typedef logic [EXE_W-1:0] exe_ctrl_t;

  typedef struct packed {
    wb_ctrl_t  wb;
    m_ctrl_t   m;
    exe_ctrl_t exe;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard compare: a valid load in EX whose destination (rt, nonzero)
// is a source of the valid instruction currently in ID.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              i_ex_memread,
  input  logic              i_ex_valid,
  input  logic [REG_AW-1:0] i_ex_rt,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  output logic              o_hazard
);

  logic w_load_in_ex;
  logic w_dep;

  always_comb begin
    w_load_in_ex = i_ex_memread & i_ex_valid & (i_ex_rt != '0);
    w_dep        = i_id_valid & ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));
    o_hazard     = w_load_in_ex & w_dep;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch-flush bubble insertion.
// Optional perf counters (stall/flush cycles) enabled by `ID_EX_PERF_CNT_EN.
import mips_pipe_pkg::*;

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WB_W-1:0]   id_wb_i,
  input  logic [M_W-1:0]    id_m_i,
  input  logic [EXE_W-1:0]  id_exe_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rd1_i,
  input  logic [DATA_W-1:0] id_rd2_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [WB_W-1:0]   ex_wb_o,
  output logic [M_W-1:0]    ex_m_o,
  output logic [EXE_W-1:0]  ex_exe_o,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_rd1_o,
  output logic [DATA_W-1:0] ex_rd2_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  ctrl_t             r_ctrl;
  logic              r_valid;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc4;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;

  logic              w_hazard;
  logic              w_bubble;
  ctrl_t             w_id_ctrl;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .i_ex_memread(r_ctrl.m[M_MEMREAD_BIT]),
    .i_ex_valid  (r_valid),
    .i_ex_rt     (r_rt),
    .i_id_valid  (id_valid_i),
    .i_id_rs     (id_rs_i),
    .i_id_rt     (id_rt_i),
    .o_hazard    (w_hazard)
  );

  always_comb begin
    stall_o   = w_hazard & ~flush_i;
    w_bubble  = flush_i | w_hazard;
    w_id_ctrl = '0;
    if (id_valid_i) begin
      w_id_ctrl.wb  = id_wb_i;
      w_id_ctrl.m   = id_m_i;
      w_id_ctrl.exe = id_exe_i;
    end
  end

  // Datapath always follows ID; only control and valid are squashed by a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_pc4   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else begin
      r_rd1 <= id_rd1_i;
      r_rd2 <= id_rd2_i;
      r_imm <= id_imm_i;
      r_pc4 <= id_pc4_i;
      r_rs  <= id_rs_i;
      r_rt  <= id_rt_i;
      r_rd  <= id_rd_i;
      if (w_bubble) begin
        r_ctrl  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_ctrl  <= w_id_ctrl;
        r_valid <= id_valid_i;
      end
    end
  end

  assign ex_wb_o    = r_ctrl.wb;
  assign ex_m_o     = r_ctrl.m;
  assign ex_exe_o   = r_ctrl.exe;
  assign ex_valid_o = r_valid;
  assign ex_rd1_o   = r_rd1;
  assign ex_rd2_o   = r_rd2;
  assign ex_imm_o   = r_imm;
  assign ex_pc4_o   = r_pc4;
  assign ex_rs_o    = r_rs;
  assign ex_rt_o    = r_rt;
  assign ex_rd_o    = r_rd;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_o && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush_i && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// against a behavioural model; counter checks when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef ID_EX_PERF_CNT_EN
  localparam int CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    id_wb_i;
  logic [2:0]    id_m_i;
  logic [3:0]    id_exe_i;
  logic          id_valid_i;
  logic [DW-1:0] id_rd1_i, id_rd2_i, id_imm_i, id_pc4_i;
  logic [AW-1:0] id_rs_i, id_rt_i, id_rd_i;
  logic          flush_i;
  logic          stall_o;
  logic [1:0]    ex_wb_o;
  logic [2:0]    ex_m_o;
  logic [3:0]    ex_exe_o;
  logic          ex_valid_o;
  logic [DW-1:0] ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc4_o;
  logic [AW-1:0] ex_rs_o, ex_rt_o, ex_rd_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(
    .DATA_W(DW),
    .REG_AW(AW)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .CNT_W (CW)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .id_wb_i(id_wb_i), .id_m_i(id_m_i), .id_exe_i(id_exe_i), .id_valid_i(id_valid_i),
    .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i), .id_imm_i(id_imm_i), .id_pc4_i(id_pc4_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .flush_i(flush_i),
    .stall_o(stall_o),
    .ex_wb_o(ex_wb_o), .ex_m_o(ex_m_o), .ex_exe_o(ex_exe_o), .ex_valid_o(ex_valid_o),
    .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o), .ex_imm_o(ex_imm_o), .ex_pc4_o(ex_pc4_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  // Expected contents of the EX stage, as the pipeline rules describe it.
  typedef struct {
    logic [1:0]    wb;
    logic [2:0]    m;
    logic [3:0]    exe;
    logic          valid;
    logic [DW-1:0] rd1, rd2, imm, pc4;
    logic [AW-1:0] rs, rt, rd;
  } ex_s;

  ex_s         mdl;
  int unsigned m_stall_cnt;
  int unsigned m_flush_cnt;
  int          errs   = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl = '{wb: 0, m: 0, exe: 0, valid: 0, rd1: 0, rd2: 0, imm: 0, pc4: 0, rs: 0, rt: 0, rd: 0};
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  function automatic bit model_hazard();
    bit load_in_ex;
    bit dependent;
    load_in_ex = mdl.valid && mdl.m[1] && (mdl.rt != 0);
    dependent  = id_valid_i && ((mdl.rt == id_rs_i) || (mdl.rt == id_rt_i));
    return load_in_ex && dependent;
  endfunction

  task automatic check_ex(input string tag);
    chk({tag, ".ctrl"},  {ex_wb_o, ex_m_o, ex_exe_o}, {mdl.wb, mdl.m, mdl.exe});
    chk({tag, ".valid"}, ex_valid_o, mdl.valid);
    if (mdl.valid) begin
      chk({tag, ".data"}, {ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc4_o},
          {mdl.rd1, mdl.rd2, mdl.imm, mdl.pc4});
      chk({tag, ".regs"}, {ex_rs_o, ex_rt_o, ex_rd_o}, {mdl.rs, mdl.rt, mdl.rd});
    end
`ifdef ID_EX_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt_o, m_stall_cnt);
    chk({tag, ".flush_cnt"}, flush_cnt_o, m_flush_cnt);
`endif
  endtask

  // One clock: check stall before the edge, advance the model, check EX after it.
  task automatic step(input string tag);
    bit hz;
    bit exp_stall;
    #1;
    hz        = model_hazard();
    exp_stall = hz && !flush_i;
    chk({tag, ".stall"}, stall_o, exp_stall);
    @(posedge clk);
    if (exp_stall && m_stall_cnt < 32'hFFFF_FFFF) m_stall_cnt++;
    if (flush_i && m_flush_cnt < 32'hFFFF_FFFF) m_flush_cnt++;
`ifdef ID_EX_PERF_CNT_EN
    if (m_stall_cnt > CMAX) m_stall_cnt = CMAX;
    if (m_flush_cnt > CMAX) m_flush_cnt = CMAX;
`endif
    mdl.rd1 = id_rd1_i; mdl.rd2 = id_rd2_i; mdl.imm = id_imm_i; mdl.pc4 = id_pc4_i;
    mdl.rs  = id_rs_i;  mdl.rt  = id_rt_i;  mdl.rd  = id_rd_i;
    if (flush_i || hz || !id_valid_i) begin
      mdl.wb = 0; mdl.m = 0; mdl.exe = 0;
      mdl.valid = id_valid_i && !flush_i && !hz;
    end else begin
      mdl.wb = id_wb_i; mdl.m = id_m_i; mdl.exe = id_exe_i; mdl.valid = 1'b1;
    end
    #1;
    check_ex(tag);
  endtask

  task automatic set_id(input logic v, input logic [1:0] wb, input logic [2:0] m,
                        input logic [3:0] exe, input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt, input logic [AW-1:0] rd);
    id_valid_i = v; id_wb_i = wb; id_m_i = m; id_exe_i = exe;
    id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
    id_rd1_i = $urandom; id_rd2_i = $urandom; id_imm_i = $urandom; id_pc4_i = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    set_id(1'b0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ctrl", {ex_wb_o, ex_m_o, ex_exe_o, ex_valid_o}, '0);
    chk("reset.data", {ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc4_o}, '0);
    chk("reset.regs", {ex_rs_o, ex_rt_o, ex_rd_o}, '0);
    chk("reset.stall", stall_o, 1'b0);
    rst = 1'b0;

    // R-type
    set_id(1'b1, 2'd2, 3'd0, 4'd12, 5'd1, 5'd2, 5'd3);
    step("rtype");
    set_id(1'b1, 2'd2, 3'd0, 4'd12, 5'd3, 5'd1, 5'd4);
    step("rtype2");

    // LW rt=5 then dependent ADD rs=5: one stall, then ADD passes
    set_id(1'b1, 2'd3, 3'd2, 4'd0, 5'd1, 5'd5, 5'd0);
    step("lw5");
    set_id(1'b1, 2'd2, 3'd0, 4'd12, 5'd5, 5'd6, 5'd7);
    step("add_stall");
    chk("add_stall.valid_direct", ex_valid_o, 1'b0);
    step("add_pass");
    chk("add_pass.valid_direct", ex_valid_o, 1'b1);

    // LW to r0 never stalls
    set_id(1'b1, 2'd3, 3'd2, 4'd0, 5'd1, 5'd0, 5'd0);
    step("lw0");
    set_id(1'b1, 2'd2, 3'd0, 4'd12, 5'd0, 5'd0, 5'd8);
    step("add_r0");

    // Flush coincident with a hazard: single bubble, no stall
    set_id(1'b1, 2'd3, 3'd2, 4'd0, 5'd2, 5'd7, 5'd0);
    step("lw7");
    set_id(1'b1, 2'd2, 3'd0, 4'd12, 5'd7, 5'd1, 5'd9);
    flush_i = 1'b1;
    step("flush_hz");
    flush_i = 1'b0;
    set_id(1'b1, 2'd2, 3'd0, 4'd12, 5'd7, 5'd1, 5'd9);
    step("after_flush");

    // All-zero instruction passes valid with zero controls
    set_id(1'b1, 0, 0, 0, 0, 0, 0);
    id_rd1_i = '0; id_rd2_i = '0; id_imm_i = '0; id_pc4_i = '0;
    step("nop");

    // Invalid ID with nonzero fields: controls must load as zero
    set_id(1'b0, 2'd3, 3'd7, 4'd15, 5'd4, 5'd4, 5'd4);
    step("invalid");

    for (int i = 0; i < 300; i++) begin
      set_id(($urandom_range(0, 7) != 0), 2'($urandom), 3'($urandom), 4'($urandom),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom));
      flush_i = ($urandom_range(0, 7) == 0);
      step("rand");
    end
    flush_i = 1'b0;

    // Asynchronous reset mid-cycle with nonzero inputs
    set_id(1'b1, 2'd3, 3'd2, 4'd9, 5'd6, 5'd6, 5'd6);
    step("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.ctrl", {ex_wb_o, ex_m_o, ex_exe_o, ex_valid_o}, '0);
    chk("async_rst.data", {ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc4_o, ex_rs_o, ex_rt_o, ex_rd_o}, '0);
    @(posedge clk);
    #1;
    chk("hold_rst.all", {ex_wb_o, ex_m_o, ex_exe_o, ex_valid_o, ex_rd1_o, ex_rd2_o, ex_imm_o,
                         ex_pc4_o, ex_rs_o, ex_rt_o, ex_rd_o}, '0);
`ifdef ID_EX_PERF_CNT_EN
    chk("hold_rst.cnt", {stall_cnt_o, flush_cnt_o}, '0);
`endif
    model_reset();
    rst = 1'b0;
    step("post_rst");

`ifdef ID_EX_PERF_CNT_EN
    for (int i = 0; i < 20; i++) begin
      set_id(1'b1, 2'd3, 3'd2, 4'd0, 5'd1, 5'd5, 5'd0);
      step("cnt_lw");
      set_id(1'b1, 2'd2, 3'd0, 4'd12, 5'd5, 5'd2, 5'd3);
      step("cnt_stall");
      step("cnt_pass");
    end
    chk("stall_cnt_sat", stall_cnt_o, 4'd15);
    model_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    set_id(1'b1, 2'd2, 3'd0, 4'd12, 5'd1, 5'd2, 5'd3);
    flush_i = 1'b1;
    repeat (3) step("cnt_flush");
    flush_i = 1'b0;
    step("cnt_flush_end");
    chk("flush_cnt3", flush_cnt_o, 4'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
